// File: rtl/vga_timing_if.sv
// vga_timing_if: pixel-tick input and registered sync/address/strobe outputs of the timing generator
//   pix_en       pixel tick into the generator
//   hsync_sig    horizontal sync
//   vsync_sig    vertical sync
//   ready        display enable, high inside the active window
//   column_addr  x coordinate while ready, else 0
//   row_addr     y coordinate while ready, else 0
//   line_start   one-clk strobe on the first tick of each line
//   frame_start  one-clk strobe on the first tick of each frame
interface vga_timing_if #(parameter int CW = 11);
   logic          pix_en;
   logic          hsync_sig;
   logic          vsync_sig;
   logic          ready;
   logic [CW-1:0] column_addr;
   logic [CW-1:0] row_addr;
   logic          line_start;
   logic          frame_start;
   modport master (input pix_en, output hsync_sig, vsync_sig, ready, column_addr, row_addr, line_start, frame_start);
   modport slave (output pix_en, input hsync_sig, vsync_sig, ready, column_addr, row_addr, line_start, frame_start);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync and pixel-address generator with pixel-clock enable
//   clk    system/pixel clock
//   rst_n  asynchronous active-low reset
//   vif    master side of vga_timing_if: pix_en in; syncs, ready, addresses, strobes out (all registered)
module vga_timing_gen #(
   parameter int H_SYNC = 128,
   parameter int H_BP   = 88,
   parameter int H_ACT  = 800,
   parameter int H_FP   = 40,
   parameter int V_SYNC = 4,
   parameter int V_BP   = 23,
   parameter int V_ACT  = 600,
   parameter int V_FP   = 1,
   parameter bit HS_POL = 1'b0,
   parameter bit VS_POL = 1'b0,
   parameter int CW     = 11
) (
   input  logic clk,
   input  logic rst_n,
   vga_timing_if.master vif
);
   localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
   localparam int HA0 = H_SYNC + H_BP;
   localparam int VA0 = V_SYNC + V_BP;
   logic [CW-1:0] h_cnt, v_cnt, col_d, row_d, column_addr, row_addr;
   logic h_wrap, v_wrap, hs_act, vs_act, rdy_d;
   logic hsync_sig, vsync_sig, ready, line_start, frame_start;
   int h, v;
   always_comb begin
      h      = int'(h_cnt);
      v      = int'(v_cnt);
      h_wrap = h == H_TOTAL - 1;
      v_wrap = v == V_TOTAL - 1;
      hs_act = h < H_SYNC;
      vs_act = v < V_SYNC;
      rdy_d  = h >= HA0 && h < HA0 + H_ACT && v >= VA0 && v < VA0 + V_ACT;
      col_d  = rdy_d ? h_cnt - CW'(HA0) : '0;
      row_d  = rdy_d ? v_cnt - CW'(VA0) : '0;
   end
   // strobes load every clk so they fall on the very next clk even with a sparse pix_en
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         hsync_sig   <= ~HS_POL;
         vsync_sig   <= ~VS_POL;
         ready       <= 1'b0;
         column_addr <= '0;
         row_addr    <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= vif.pix_en && h_cnt == '0;
         frame_start <= vif.pix_en && h_cnt == '0 && v_cnt == '0;
         if (vif.pix_en) begin
            hsync_sig   <= hs_act ~^ HS_POL;
            vsync_sig   <= vs_act ~^ VS_POL;
            ready       <= rdy_d;
            column_addr <= col_d;
            row_addr    <= row_d;
            h_cnt       <= h_wrap ? '0 : h_cnt + 1'b1;
            if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
         end
      end
   end
   assign vif.hsync_sig   = hsync_sig;
   assign vif.vsync_sig   = vsync_sig;
   assign vif.ready       = ready;
   assign vif.column_addr = column_addr;
   assign vif.row_addr    = row_addr;
   assign vif.line_start  = line_start;
   assign vif.frame_start = frame_start;
endmodule
